// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one request in flight
// to instruction memory, and holds the IF/ID register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active low
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic [1:0]  pc_src,
  input  logic [23:0] jump_imm,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] Instruction,
  output logic [31:0] PC_Reg,
  output logic [31:0] PC_Next,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;         // next address to request
  logic [31:0] req_pc_q, req_pc_d;   // address of the request in flight
  logic        kill_q, kill_d;       // in-flight response belongs to a stale path
  logic        buf_vld_q, buf_vld_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        ifv_q, ifv_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_reg_q, pc_reg_d;
  logic [31:0] pc_nxt_q, pc_nxt_d;

  logic        gnt_acc, rsp, redirect, drop, deliver, slot_free;
  logic [31:0] target;

  // Handshake qualification, redirect decode and response classification
  always_comb begin
    imem_req  = (state_q == REQ) && !buf_vld_q;
    gnt_acc   = imem_req && imem_gnt;
    rsp       = (state_q == WAIT) && imem_rvalid;
    redirect  = ifv_q && !id_stall && pc_src[1] && (state_q != HALT);
    target    = (pc_src == 2'b10) ? {pc_reg_q[31:24], jump_imm} : branch_target;
    drop      = rsp && (kill_q || redirect);
    deliver   = rsp && !drop;
    slot_free = !ifv_q || !id_stall;
  end

  // Next-state logic: a delivered stop word freezes fetch for good
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (gnt_acc) state_d = WAIT;
      WAIT: if (rsp) state_d = (deliver && imem_rdata[31]) ? HALT : REQ;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC, kill flag, skid buffer and IF/ID next values
  always_comb begin
    fpc_d     = fpc_q;
    req_pc_d  = req_pc_q;
    kill_d    = kill_q;
    buf_vld_d = buf_vld_q;
    buf_ins_d = buf_ins_q;
    buf_pc_d  = buf_pc_q;
    ifv_d     = ifv_q;
    ins_d     = ins_q;
    pc_reg_d  = pc_reg_q;
    pc_nxt_d  = pc_nxt_q;

    if (gnt_acc) begin
      req_pc_d = fpc_q;
      fpc_d    = fpc_q + PC_INC;
    end
    if (redirect) fpc_d = target;

    // A response always retires the kill; a redirect with nothing yet
    // returned marks whatever is still in flight as stale.
    if (rsp) kill_d = 1'b0;
    if (redirect && ((state_q == WAIT && !rsp) || gnt_acc)) kill_d = 1'b1;

    if (redirect) begin
      ifv_d     = 1'b0;
      buf_vld_d = 1'b0;
    end else if (buf_vld_q && !id_stall) begin
      ifv_d     = 1'b1;
      ins_d     = buf_ins_q;
      pc_reg_d  = buf_pc_q;
      pc_nxt_d  = buf_pc_q + PC_INC;
      buf_vld_d = 1'b0;
    end else if (deliver && slot_free) begin
      ifv_d    = 1'b1;
      ins_d    = imem_rdata;
      pc_reg_d = req_pc_q;
      pc_nxt_d = req_pc_q + PC_INC;
    end else if (deliver) begin
      buf_vld_d = 1'b1;
      buf_ins_d = imem_rdata;
      buf_pc_d  = req_pc_q;
    end else if (!id_stall) begin
      ifv_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fpc_q     <= RESET_PC;
      req_pc_q  <= '0;
      kill_q    <= 1'b0;
      buf_vld_q <= 1'b0;
      buf_ins_q <= '0;
      buf_pc_q  <= '0;
      ifv_q     <= 1'b0;
      ins_q     <= '0;
      pc_reg_q  <= '0;
      pc_nxt_q  <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      req_pc_q  <= req_pc_d;
      kill_q    <= kill_d;
      buf_vld_q <= buf_vld_d;
      buf_ins_q <= buf_ins_d;
      buf_pc_q  <= buf_pc_d;
      ifv_q     <= ifv_d;
      ins_q     <= ins_d;
      pc_reg_q  <= pc_reg_d;
      pc_nxt_q  <= pc_nxt_d;
    end
  end

  assign imem_addr   = fpc_q;
  assign if_valid    = ifv_q;
  assign Instruction = ins_q;
  assign PC_Reg      = pc_reg_q;
  assign PC_Next     = pc_nxt_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, redirect vector table,
// hand sequences for stall/stop/reset, and a random-stall scoreboard run.
module tb_fetch_stage;

  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_stall;
  logic [1:0]  pc_src;
  logic [23:0] jump_imm;
  logic [31:0] branch_target;
  logic        if_valid, halted;
  logic [31:0] Instruction, PC_Reg, PC_Next;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .pc_src(pc_src), .jump_imm(jump_imm),
    .branch_target(branch_target),
    .if_valid(if_valid), .Instruction(Instruction), .PC_Reg(PC_Reg),
    .PC_Next(PC_Next), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_cons = 0;

  // responder state
  logic        pend, granted, sb_en;
  int          pcnt, rdly;
  logic [31:0] paddr, gaddr, stop_addr, sb_pc;
  logic [31:0] sbq[$];

  typedef struct {
    logic [31:0] base;
    logic [1:0]  src;
    logic [23:0] imm;
    logic [31:0] bt;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[6];

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == stop_addr) return 32'h8000_0000;
    if (a == 32'h0) return 32'h0000_0021;
    return {8'h15, a[23:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: condition not reached within bound (t=%0t)", nm, $time);
  endtask

  // One cycle: memory response/grant, optional random stall and decode-side check
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    imem_rvalid = 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(paddr);
        pend        = 1'b0;
      end else pcnt--;
    end
    granted  = imem_req;
    imem_gnt = granted;
    if (granted) begin
      paddr = imem_addr;
      gaddr = imem_addr;
      pend  = 1'b1;
      pcnt  = rdly;
      if (sb_en) begin
        chk("sb_req_addr", imem_addr, sb_pc);
        sbq.push_back(sb_pc);
        sb_pc = sb_pc + 32'd1;
      end
    end
    if (sb_en) begin
      id_stall = ($urandom_range(0, 9) < 4);
      if (if_valid && !id_stall) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: IF/ID pc %h with nothing expected", PC_Reg);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc", PC_Reg, e);
          chk("sb_instr", Instruction, mem(e));
          chk("sb_next", PC_Next, e + 32'd1);
          n_cons++;
        end
      end
    end
  endtask

  task automatic chk_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ifv", if_valid, 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_pcreg", PC_Reg, 0);
    chk("rst_pcnext", PC_Next, 0);
    chk("rst_halted", halted, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pend = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    sbq.delete();
    sb_pc = 32'h0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    do begin
      step();
      k++;
    end while (!if_valid && k < 30);
    if (!if_valid) fail_now(nm);
  endtask

  // Branch-redirect so that IF/ID ends up holding base, with the next
  // sequential grant already on the wire.
  task automatic redirect_to(input logic [31:0] base);
    int k = 0;
    if (!if_valid) wait_valid("rt_pre");
    pc_src = 2'b11;
    branch_target = base;
    id_stall = 1'b0;
    step();
    pc_src = 2'b01;
    do begin
      step();
      k++;
    end while (!(if_valid && PC_Reg == base) && k < 40);
    if (!(if_valid && PC_Reg == base)) fail_now("rt_reach");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h1200_0005, 2'b10, 24'h00_0040, 32'hDEAD_0000, 32'h1200_0040};
    vt[1] = '{32'hAB12_3456, 2'b10, 24'hFF_FFFF, 32'hDEAD_0000, 32'hABFF_FFFF};
    vt[2] = '{32'h0000_0007, 2'b11, 24'h00_0040, 32'h0000_1000, 32'h0000_1000};
    vt[3] = '{32'h1200_0005, 2'b01, 24'h00_0040, 32'hDEAD_0000, 32'h1200_0006};
    vt[4] = '{32'h1200_0005, 2'b00, 24'h00_0040, 32'hDEAD_0000, 32'h1200_0006};
    vt[5] = '{32'h0000_0010, 2'b11, 24'h00_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_stall = 1'b0; pc_src = 2'b01; jump_imm = '0; branch_target = '0;
    pend = 1'b0; granted = 1'b0; sb_en = 1'b0; pcnt = 0; rdly = 0;
    paddr = '0; gaddr = '0; stop_addr = 32'hFFFF_0000; sb_pc = '0;
    #3;
    chk_reset();
    step();
    rst = 1'b1;

    // first fetch after reset
    step();
    chk("t1_gnt", granted, 1);
    chk("t1_addr", gaddr, 32'h0);
    step();
    chk("t1_wait_req", imem_req, 0);
    step();
    chk("t1_ifv", if_valid, 1);
    chk("t1_instr", Instruction, 32'h0000_0021);
    chk("t1_pcreg", PC_Reg, 32'h0);
    chk("t1_pcnext", PC_Next, 32'h1);
    chk("t1_next_addr", gaddr, 32'h1);

    // redirect vector table
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e1;
      e1 = vt[i].exp_pc + 32'd1;
      redirect_to(vt[i].base);
      pc_src = vt[i].src;
      jump_imm = vt[i].imm;
      branch_target = vt[i].bt;
      id_stall = 1'b0;
      step();
      pc_src = 2'b01;
      wait_valid("vec_wait");
      chk($sformatf("vec%0d_pcreg", i), PC_Reg, vt[i].exp_pc);
      chk($sformatf("vec%0d_pcnext", i), PC_Next, e1);
      chk($sformatf("vec%0d_instr", i), Instruction, mem(vt[i].exp_pc));
      chk($sformatf("vec%0d_gnt", i), granted, 1);
      chk($sformatf("vec%0d_gaddr", i), gaddr, e1);
    end

    // jump taken while the fetch sits in WAIT with a slow response
    rdly = 2;
    redirect_to(32'h1200_0005);
    id_stall = 1'b1;
    step();
    chk("w_state_noreq", imem_req, 0);
    pc_src = 2'b10; jump_imm = 24'h00_0040; id_stall = 1'b0;
    step();
    pc_src = 2'b01;
    chk("w_ifv_drop", if_valid, 0);
    wait_valid("w_wait");
    chk("w_pcreg", PC_Reg, 32'h1200_0040);
    chk("w_instr", Instruction, mem(32'h1200_0040));
    rdly = 0;

    // decode stall while a response returns: captured in the buffer
    redirect_to(32'h0000_0300);
    id_stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("s_ifv", if_valid, 1);
      chk("s_pcreg", PC_Reg, 32'h300);
      chk("s_instr", Instruction, mem(32'h300));
      chk("s_nogrant", granted, 0);
    end
    id_stall = 1'b0;
    step();
    chk("s_rel_pcreg", PC_Reg, 32'h301);
    chk("s_rel_instr", Instruction, mem(32'h301));
    chk("s_rel_gaddr", gaddr, 32'h302);

    // stop instruction freezes fetch; a later branch is ignored
    stop_addr = 32'h501;
    redirect_to(32'h500);
    step();
    chk("h_not_yet", halted, 0);
    step();
    chk("h_ifv", if_valid, 1);
    chk("h_instr", Instruction, 32'h8000_0000);
    chk("h_pcreg", PC_Reg, 32'h501);
    chk("h_halted", halted, 1);
    pc_src = 2'b11; branch_target = 32'h40; id_stall = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      pc_src = 2'b01;
      chk("h_noreq", imem_req, 0);
    end
    chk("h_addr_frozen", imem_addr, 32'h502);
    chk("h_still", halted, 1);
    stop_addr = 32'hFFFF_0000;

    // reset pulse while a response is outstanding
    do_reset();
    rdly = 2;
    step();
    chk("r_gaddr0", gaddr, 32'h0);
    step();
    #2 rst = 1'b0;
    #1 chk_reset();
    step();
    rst = 1'b1;
    rdly = 0;
    step();
    chk("r_restart_gnt", granted, 1);
    chk("r_restart_addr", gaddr, 32'h0);
    step();
    chk("r_stale_ignored", if_valid, 0);
    step();
    chk("r_ifv", if_valid, 1);
    chk("r_pcreg", PC_Reg, 32'h0);
    chk("r_instr", Instruction, 32'h21);

    // sequential stream with random decode stalls against the scoreboard
    do_reset();
    sb_en = 1'b1;
    repeat (300) step();
    sb_en = 1'b0;
    id_stall = 1'b0;
    n_chk++;
    if (n_cons < 40) begin
      n_fail++;
      $display("FAIL sb_progress: consumed %0d expected at least 40", n_cons);
    end
    n_chk++;
    if (sbq.size() > 3) begin
      n_fail++;
      $display("FAIL sb_backlog: %0d pending expected at most 3", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
